adder_job_sequencer: RTL and testbench
======================================

Name: adder_job_sequencer

Overview:
- AXI4-Lite master that runs one complete addition job on the memory-mapped adder slave.
- Accepts an operand pair on a valid/ready job port, then performs four AXI-Lite transactions in order:
  - write operand A to BASE+0x0
  - write operand B to BASE+0x4
  - read the sum from BASE+0x8
  - read the overflow flag from BASE+0xC
- Returns sum, overflow and error status on a valid/ready result port.
- Sits between a processing client and the adder slave, replacing ad-hoc testbench/CPU sequencing.

Parameters:
- DATA_WIDTH, 32, width of operands, AXI data and the sum.
- ADDR_WIDTH, 8, AXI address width.
- BASE_ADDR, 0, slave base address; register offsets are added to it modulo 2**ADDR_WIDTH.
- TIMEOUT, 256, maximum cycles any single AXI phase may wait for its handshake; minimum 2.

Ports:
- m1_axi_aclk  in  1  clock.
- m1_axi_aresetn  in  1  reset, asynchronous, active-low.
- job_valid  in  1  job request.
- job_ready  out  1  sequencer idle, can accept a job.
- job_opa  in  DATA_WIDTH  operand A.
- job_opb  in  DATA_WIDTH  operand B.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_sum  out  DATA_WIDTH  sum read from the slave.
- res_ovf  out  1  overflow, bit 0 of the overflow register.
- res_err  out  1  a response error or timeout occurred.
- m1_axi_awaddr  out  ADDR_WIDTH  write address.
- m1_axi_awvalid  out  1  write address valid.
- m1_axi_awready  in  1  write address ready.
- m1_axi_wdata  out  DATA_WIDTH  write data.
- m1_axi_wstrb  out  DATA_WIDTH/8  write strobes, always all ones.
- m1_axi_wvalid  out  1  write data valid.
- m1_axi_wready  in  1  write data ready.
- m1_axi_bresp  in  2  write response.
- m1_axi_bvalid  in  1  write response valid.
- m1_axi_bready  out  1  write response ready.
- m1_axi_araddr  out  ADDR_WIDTH  read address.
- m1_axi_arvalid  out  1  read address valid.
- m1_axi_arready  in  1  read address ready.
- m1_axi_rdata  in  DATA_WIDTH  read data.
- m1_axi_rresp  in  2  read response.
- m1_axi_rvalid  in  1  read data valid.
- m1_axi_rready  out  1  read data ready.

Behaviour:
- Reset values, applied asynchronously while m1_axi_aresetn=0:
  - state=IDLE.
  - All valid/ready outputs 0, except job_ready=1.
  - res_sum=0, res_ovf=0, res_err=0, addresses and wdata 0, wstrb all ones.
  - Operand latches and timeout counter cleared.
- Reset mid-job aborts immediately. There is no AXI completion.
- States: IDLE, WA, WA_RSP, WB, WB_RSP, RS, RS_DAT, RO, RO_DAT, DONE.
- IDLE:
  - job_ready=1.
  - On job_valid&job_ready, latch opA/opB, clear res_err, go to WA.
- WA / WB (write address and data phase):
  - Assert awvalid and wvalid in the same cycle.
  - awaddr = BASE+0x0 (WA) or BASE+0x4 (WB); wdata = latched opA or opB.
  - awvalid drops the cycle after its own handshake; wvalid likewise, independently. Either handshake may come first or both may be simultaneous.
  - Once both handshakes have completed, go to *_RSP.
  - Payloads stay stable while valid is high.
- WA_RSP / WB_RSP:
  - bready=1; wait for bvalid.
  - If bresp[1]=1, set res_err and go to DONE. Otherwise go to WB (from WA_RSP) or RS (from WB_RSP).
- RS / RO (read address phase):
  - arvalid=1 with araddr = BASE+0x8 (RS) or BASE+0xC (RO).
  - On arready, go to RS_DAT or RO_DAT.
- RS_DAT / RO_DAT:
  - rready=1; on rvalid, capture data.
  - RS_DAT: res_sum←rdata, then go to RO.
  - RO_DAT: res_ovf←rdata[0], then go to DONE.
  - If rresp[1]=1, set res_err and go to DONE. The field is captured regardless.
- Timeout:
  - Counter clears on every state entry and increments each cycle spent in a non-IDLE, non-DONE state.
  - On reaching TIMEOUT-1 without the awaited handshake: set res_err, deassert all AXI valid/ready next cycle, go to DONE.
  - Protocol break on timeout is intentional. Sum/ovf keep whatever was captured so far.
- DONE:
  - res_valid=1, outputs stable.
  - On res_ready, go to IDLE; job_ready=1 in the following cycle.
  - job_valid is ignored outside IDLE.
- Latency: minimum with zero-wait slave = 11 cycles from job accept to res_valid (2 per write phase, 1 per response, 1+1 per read, 1 to DONE).
- Only one AXI transaction is outstanding at a time. Address and write channels are never active during read states, and vice versa.

Test Plan:
- Zero-wait slave, opA=0x0000_0005, opB=0x0000_0007 → writes 0x5@0x0 and 0x7@0x4, reads @0x8 then @0xC; res_sum=0xC, res_ovf=0, res_err=0, res_valid 11 cycles after accept.
- opA=0xFFFF_FFFF, opB=0x0000_0001, slave returns sum 0x0, ovf 0x1 → res_sum=0x0, res_ovf=1, res_err=0.
- Slave holds wready 3 cycles after awready → awvalid drops after 1 cycle, wvalid held 4 cycles with wdata stable; WA_RSP entered only after both handshakes.
- bresp=2'b10 on the operand-B write → no AR issued, res_err=1, res_valid=1; res_ready held 0 for 5 cycles → outputs stable, job_ready=0.
- arready never asserted in RS, TIMEOUT=16 → arvalid drops after 16 cycles, res_err=1, res_sum=0.
- Assert aresetn low in RS_DAT → all AXI valid/ready 0 immediately, job_ready=1 after release; next job completes normally.

Source files
------------

// File: rtl/adder_job_sequencer.sv
// AXI4-Lite master for one add job: write A, write B, read sum, read overflow (min 11 cycles accept-to-result).
// One AXI transaction in flight at a time; the result is held in DONE until res_ready, and job_valid is ignored outside IDLE.
module adder_job_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    TIMEOUT    = 256
) (
  input  logic                    m1_axi_aclk,
  input  logic                    m1_axi_aresetn,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [DATA_WIDTH-1:0]   job_opa,
  input  logic [DATA_WIDTH-1:0]   job_opb,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_sum,
  output logic                    res_ovf,
  output logic                    res_err,
  output logic [ADDR_WIDTH-1:0]   m1_axi_awaddr,
  output logic                    m1_axi_awvalid,
  input  logic                    m1_axi_awready,
  output logic [DATA_WIDTH-1:0]   m1_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m1_axi_wstrb,
  output logic                    m1_axi_wvalid,
  input  logic                    m1_axi_wready,
  input  logic [1:0]              m1_axi_bresp,
  input  logic                    m1_axi_bvalid,
  output logic                    m1_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m1_axi_araddr,
  output logic                    m1_axi_arvalid,
  input  logic                    m1_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m1_axi_rdata,
  input  logic [1:0]              m1_axi_rresp,
  input  logic                    m1_axi_rvalid,
  output logic                    m1_axi_rready
);

  localparam int                    CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]         CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_A   = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] ADDR_B   = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_S   = BASE_ADDR + ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_O   = BASE_ADDR + ADDR_WIDTH'(12);

  typedef enum logic [3:0] {
    IDLE, WA, WA_RSP, WB, WB_RSP, RS, RS_DAT, RO, RO_DAT, DONE
  } state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] opa, opb;
  logic                  aw_done, w_done;
  logic [CW-1:0]         tmo_cnt;
  logic                  err_set;
  logic                  unused_resp;

  assign unused_resp = m1_axi_bresp[0] ^ m1_axi_rresp[0];

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    case (state)
      IDLE:   if (job_valid) state_nx = WA;
      WA:     if (aw_done && w_done) state_nx = WA_RSP;
      WB:     if (aw_done && w_done) state_nx = WB_RSP;
      WA_RSP, WB_RSP: begin
        if (m1_axi_bvalid) begin
          if (m1_axi_bresp[1]) begin
            err_set  = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = (state == WA_RSP) ? WB : RS;
          end
        end
      end
      RS:     if (m1_axi_arready) state_nx = RS_DAT;
      RO:     if (m1_axi_arready) state_nx = RO_DAT;
      RS_DAT: begin
        if (m1_axi_rvalid) begin
          err_set  = m1_axi_rresp[1];
          state_nx = m1_axi_rresp[1] ? DONE : RO;
        end
      end
      RO_DAT: begin
        if (m1_axi_rvalid) begin
          err_set  = m1_axi_rresp[1];
          state_nx = DONE;
        end
      end
      DONE:   if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // A phase that is still waiting on its last counted cycle is abandoned.
    if (state != IDLE && state != DONE && state_nx == state && tmo_cnt == CNT_LAST) begin
      err_set  = 1'b1;
      state_nx = DONE;
    end
  end

  always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
    if (!m1_axi_aresetn) begin
      state   <= IDLE;
      opa     <= '0;
      opb     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      tmo_cnt <= '0;
      res_sum <= '0;
      res_ovf <= 1'b0;
      res_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        tmo_cnt <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (state != IDLE && state != DONE) tmo_cnt <= tmo_cnt + 1'b1;
        if (m1_axi_awvalid && m1_axi_awready) aw_done <= 1'b1;
        if (m1_axi_wvalid && m1_axi_wready)   w_done  <= 1'b1;
      end
      if (state == IDLE && job_valid) begin
        opa     <= job_opa;
        opb     <= job_opb;
        res_err <= 1'b0;
      end
      if (err_set) res_err <= 1'b1;
      if (state == RS_DAT && m1_axi_rvalid) res_sum <= m1_axi_rdata;
      if (state == RO_DAT && m1_axi_rvalid) res_ovf <= m1_axi_rdata[0];
    end
  end

  assign job_ready      = (state == IDLE);
  assign res_valid      = (state == DONE);
  assign m1_axi_awvalid = (state == WA || state == WB) && !aw_done;
  assign m1_axi_wvalid  = (state == WA || state == WB) && !w_done;
  assign m1_axi_awaddr  = (state == WA) ? ADDR_A : (state == WB) ? ADDR_B : '0;
  assign m1_axi_wdata   = (state == WA) ? opa : (state == WB) ? opb : '0;
  assign m1_axi_wstrb   = '1;
  assign m1_axi_bready  = (state == WA_RSP || state == WB_RSP);
  assign m1_axi_arvalid = (state == RS || state == RO);
  assign m1_axi_araddr  = (state == RS) ? ADDR_S : (state == RO) ? ADDR_O : '0;
  assign m1_axi_rready  = (state == RS_DAT || state == RO_DAT);

endmodule

// File: tb/tb_adder_job_sequencer.sv
// Bench for adder_job_sequencer: adder-slave model with wait/error knobs, directed table, random jobs, corner sequences.
module tb_adder_job_sequencer;
  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          job_valid, job_ready, res_valid, res_ready, res_ovf, res_err;
  logic [DW-1:0] job_opa, job_opb, res_sum;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  adder_job_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(8'h00), .TIMEOUT(TMO)) dut (
    .m1_axi_aclk(clk), .m1_axi_aresetn(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_opa(job_opa), .job_opb(job_opb),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_ovf(res_ovf), .res_err(res_err),
    .m1_axi_awaddr(awaddr), .m1_axi_awvalid(awvalid), .m1_axi_awready(awready),
    .m1_axi_wdata(wdata), .m1_axi_wstrb(wstrb), .m1_axi_wvalid(wvalid), .m1_axi_wready(wready),
    .m1_axi_bresp(bresp), .m1_axi_bvalid(bvalid), .m1_axi_bready(bready),
    .m1_axi_araddr(araddr), .m1_axi_arvalid(arvalid), .m1_axi_arready(arready),
    .m1_axi_rdata(rdata), .m1_axi_rresp(rresp), .m1_axi_rvalid(rvalid), .m1_axi_rready(rready)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Slave knobs, written by the main sequence only
  int aw_wait, w_wait, b_wait, ar_wait, r_wait, b_err_sel, r_err_sel;
  bit ar_never;

  // Slave state, written by the slave process only
  logic [DW-1:0] sreg [4];
  logic [47:0]   log_q [$];
  int aw_hi = 0, w_hi = 0, ar_hi = 0, w_unstable = 0, viol = 0;
  bit aw_got, w_got, b_pend, r_pend, b_err_now;
  bit hs_aw, hs_w, hs_b, hs_ar, hs_r, prev_wvalid;
  int aw_c, w_c, b_c, ar_c, r_c;
  logic [AW-1:0] aw_a, r_a, hs_awaddr, hs_araddr;
  logic [DW-1:0] w_d, hs_wdata, prev_wdata;
  logic [DW:0]   full_sum;

  initial begin
    {awready, wready, bvalid, arready, rvalid} = '0;
    bresp = 2'b00; rresp = 2'b00; rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {awready, wready, bvalid, arready, rvalid} = '0;
        {aw_got, w_got, b_pend, r_pend, hs_aw, hs_w, hs_b, hs_ar, hs_r, prev_wvalid} = '0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        continue;
      end
      if (hs_aw) begin aw_got = 1; aw_a = hs_awaddr; end
      if (hs_w)  begin w_got = 1; w_d = hs_wdata; end
      if (hs_b)  b_pend = 0;
      if (hs_ar) begin r_pend = 1; r_a = hs_araddr; r_c = 0; end
      if (hs_r)  r_pend = 0;
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0;
        sreg[aw_a[3:2]] = w_d;
        log_q.push_back({8'h01, aw_a, w_d});
        b_pend = 1; b_c = 0;
        b_err_now = (b_err_sel == 1 && aw_a == 8'h00) || (b_err_sel == 2 && aw_a == 8'h04);
      end
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
      if (arvalid) ar_hi++;
      if (wvalid && prev_wvalid && !hs_w && wdata !== prev_wdata) w_unstable++;
      prev_wvalid = wvalid; prev_wdata = wdata;
      if (bready && !b_pend) viol++;
      if ((awvalid || wvalid || bready) && (arvalid || rready)) viol++;

      awready = awvalid && !aw_got && aw_c >= aw_wait;
      if (awvalid && !awready) aw_c++; else aw_c = 0;
      wready = wvalid && !w_got && w_c >= w_wait;
      if (wvalid && !wready) w_c++; else w_c = 0;
      bvalid = b_pend && b_c >= b_wait;
      bresp  = (bvalid && b_err_now) ? 2'b10 : 2'b00;
      if (b_pend) b_c++;
      arready = arvalid && !r_pend && !ar_never && ar_c >= ar_wait;
      if (arvalid && !arready) ar_c++; else ar_c = 0;
      if (r_pend) begin
        rvalid = r_c >= r_wait;
        r_c++;
        full_sum = {1'b0, sreg[0]} + {1'b0, sreg[1]};
        rdata = (r_a == 8'h08) ? full_sum[DW-1:0] : (r_a == 8'h0C) ? {{(DW-1){1'b0}}, full_sum[DW]} : '0;
        rresp = ((r_err_sel == 1 && r_a == 8'h08) || (r_err_sel == 2 && r_a == 8'h0C)) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 0;
      end

      hs_aw = awvalid && awready; hs_awaddr = awaddr;
      hs_w  = wvalid && wready;   hs_wdata  = wdata;
      hs_b  = bvalid && bready;
      hs_ar = arvalid && arready; hs_araddr = araddr;
      hs_r  = rvalid && rready;
      if (hs_r) log_q.push_back({8'h00, r_a, rdata});
    end
  end

  // Reference model: what a job should produce, given the slave's misbehaviour
  logic [DW-1:0] psum;
  bit            povf, exp_err;
  int            exp_n;
  logic [47:0]   exp_log [4];

  task automatic model(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] full;
    full = {1'b0, a} + {1'b0, b};
    exp_log[0] = {8'h01, 8'h00, a};
    exp_log[1] = {8'h01, 8'h04, b};
    exp_log[2] = {8'h00, 8'h08, full[DW-1:0]};
    exp_log[3] = {8'h00, 8'h0C, {(DW-1){1'b0}}, full[DW]};
    exp_err = 0; exp_n = 4;
    if (b_err_sel == 1)      begin exp_n = 1; exp_err = 1; end
    else if (b_err_sel == 2) begin exp_n = 2; exp_err = 1; end
    else if (ar_never)       begin exp_n = 2; exp_err = 1; end
    else if (r_err_sel == 1) begin exp_n = 3; exp_err = 1; psum = full[DW-1:0]; end
    else begin
      psum = full[DW-1:0]; povf = full[DW]; exp_err = (r_err_sel == 2);
    end
  endtask

  task automatic check_log(input int base, input string tag);
    chk({tag, "_log_len"}, log_q.size() - base, exp_n);
    for (int i = 0; i < exp_n; i++)
      if (base + i < log_q.size()) chk($sformatf("%s_log%0d", tag, i), log_q[base + i], exp_log[i]);
  endtask

  task automatic run_job(input logic [DW-1:0] a, input logic [DW-1:0] b, output int lat);
    int waited = 0;
    while (!job_ready && waited < 100) begin @(posedge clk); #1; waited++; end
    chk("job_ready_before_accept", job_ready, 1);
    job_opa = a; job_opb = b; job_valid = 1;
    @(posedge clk); #1;
    job_valid = 0; job_opa = $urandom; job_opb = $urandom;
    lat = 0;
    while (lat < 300) begin
      lat++;
      if (res_valid) break;
      @(posedge clk); #1;
    end
    chk("res_valid_arrives", res_valid, 1);
  endtask

  task automatic release_result();
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    chk("job_ready_after_release", job_ready, 1);
    chk("res_valid_after_release", res_valid, 0);
  endtask

  task automatic knobs_zero();
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    b_err_sel = 0; r_err_sel = 0; ar_never = 0;
  endtask

  typedef struct {
    logic [DW-1:0] a, b;
    int aw, w, bw, ar, r, bsel, rsel;
    logic [DW-1:0] esum;
    bit eovf, eerr;
    int elat;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int lat, base, mark, mark2, mark3;
    bit stable;
    logic [DW-1:0] ra, rb, held_sum;

    tbl[0] = '{32'h5, 32'h7, 0, 0, 0, 0, 0, 0, 0, 32'hC, 1'b0, 1'b0, 11};
    tbl[1] = '{32'hFFFF_FFFF, 32'h1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0, 11};
    tbl[2] = '{32'hDEAD_BEEF, 32'h1, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEF0, 1'b1, 1'b1, 9};
    tbl[3] = '{32'h8000_0000, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1'b1, 1'b0, 11};
    tbl[4] = '{32'h1234_5678, 32'h1111_1111, 1, 2, 1, 2, 3, 0, 0, 32'h2345_6789, 1'b0, 1'b0, 0};
    tbl[5] = '{32'h0000_000A, 32'h0000_0014, 0, 0, 0, 0, 0, 0, 2, 32'h1E, 1'b0, 1'b1, 11};

    job_valid = 0; res_ready = 0; job_opa = '0; job_opb = '0;
    knobs_zero();
    psum = '0; povf = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_axi_handshake", {awvalid, wvalid, bready, arvalid, rready}, 0);
    chk("rst_results", {res_sum, res_ovf, res_err}, 0);
    chk("rst_addr_data", {awaddr, araddr, wdata}, 0);
    chk("rst_wstrb", wstrb, 4'hF);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Read address never accepted: phase abandoned after TMO cycles
    ar_never = 1;
    base = log_q.size(); mark = ar_hi;
    run_job(32'h3, 32'h4, lat);
    model(32'h3, 32'h4);
    chk("tmo_err", res_err, 1);
    chk("tmo_sum", res_sum, 32'h0);
    chk("tmo_arvalid_cycles", ar_hi - mark, TMO);
    chk("tmo_axi_idle", {awvalid, wvalid, bready, arvalid, rready}, 0);
    check_log(base, "tmo");
    release_result();
    ar_never = 0;

    for (int i = 0; i < 6; i++) begin
      aw_wait = tbl[i].aw; w_wait = tbl[i].w; b_wait = tbl[i].bw; ar_wait = tbl[i].ar; r_wait = tbl[i].r;
      b_err_sel = tbl[i].bsel; r_err_sel = tbl[i].rsel;
      base = log_q.size();
      run_job(tbl[i].a, tbl[i].b, lat);
      model(tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d_sum", i), res_sum, tbl[i].esum);
      chk($sformatf("tbl%0d_ovf", i), res_ovf, tbl[i].eovf);
      chk($sformatf("tbl%0d_err", i), res_err, tbl[i].eerr);
      if (tbl[i].elat != 0) chk($sformatf("tbl%0d_latency", i), lat, tbl[i].elat);
      check_log(base, $sformatf("tbl%0d", i));
      release_result();
    end
    knobs_zero();

    // Write data accepted 3 cycles after the address
    w_wait = 3;
    base = log_q.size(); mark = aw_hi; mark2 = w_hi; mark3 = w_unstable;
    run_job(32'h0000_0100, 32'h0000_0023, lat);
    model(32'h0000_0100, 32'h0000_0023);
    chk("wdly_awvalid_cycles", aw_hi - mark, 2);
    chk("wdly_wvalid_cycles", w_hi - mark2, 8);
    chk("wdly_wdata_stable", w_unstable - mark3, 0);
    chk("wdly_latency", lat, 17);
    chk("wdly_sum", res_sum, psum);
    check_log(base, "wdly");
    release_result();
    knobs_zero();

    // Error response on operand-B write, result held for 5 cycles
    b_err_sel = 2;
    base = log_q.size(); mark = ar_hi;
    run_job(32'h0000_0042, 32'h0000_0099, lat);
    model(32'h0000_0042, 32'h0000_0099);
    chk("berr_err", res_err, 1);
    chk("berr_sum_kept", res_sum, psum);
    chk("berr_no_ar", ar_hi - mark, 0);
    check_log(base, "berr");
    held_sum = res_sum;
    stable = 1;
    job_valid = 1; job_opa = 32'h1; job_opb = 32'h2;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      stable &= res_valid && !job_ready && res_err && (res_sum == held_sum) && (res_ovf == povf) &&
                !(awvalid || wvalid || bready || arvalid || rready);
    end
    job_valid = 0;
    chk("berr_hold_stable", stable, 1);
    release_result();
    knobs_zero();

    for (int i = 0; i < 30; i++) begin
      ra = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = (i % 5 == 0) ? 32'h0 : $urandom;
      aw_wait = $urandom_range(0, 3); w_wait = $urandom_range(0, 3); b_wait = $urandom_range(0, 3);
      ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
      b_err_sel = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      r_err_sel = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      base = log_q.size();
      run_job(ra, rb, lat);
      model(ra, rb);
      chk($sformatf("rnd%0d_sum", i), res_sum, psum);
      chk($sformatf("rnd%0d_ovf", i), res_ovf, povf);
      chk($sformatf("rnd%0d_err", i), res_err, exp_err);
      check_log(base, $sformatf("rnd%0d", i));
      release_result();
    end
    knobs_zero();

    // Reset while waiting for read data of the sum
    r_wait = 6;
    job_opa = 32'h11; job_opb = 32'h22; job_valid = 1;
    @(posedge clk); #1;
    job_valid = 0;
    mark = 0;
    while (!rready && mark < 60) begin @(posedge clk); #1; mark++; end
    chk("rstmid_reached_rs_dat", rready, 1);
    rst_n = 0;
    #1;
    chk("rstmid_axi_idle", {awvalid, wvalid, bready, arvalid, rready, res_valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    psum = '0; povf = 0;
    @(posedge clk); #1;
    chk("rstmid_job_ready", job_ready, 1);
    chk("rstmid_sum_cleared", res_sum, 32'h0);
    knobs_zero();
    ra = $urandom; rb = $urandom;
    base = log_q.size();
    run_job(ra, rb, lat);
    model(ra, rb);
    chk("post_rst_sum", res_sum, psum);
    chk("post_rst_ovf", res_ovf, povf);
    chk("post_rst_err", res_err, 0);
    chk("post_rst_latency", lat, 11);
    check_log(base, "post_rst");
    release_result();

    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
